// File: rtl/drone_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// drone_pkg - shared channel count, state encodings and width type
// Rev 1.0 - initial release
// ----------------------------------------------------------------------
package drone_pkg;

  localparam int NUM_CH  = 4;
  localparam int WIDTH_W = 11;

  typedef logic [WIDTH_W-1:0] width_t;

  typedef enum logic [1:0] {
    S_DISARMED = 2'b00,
    S_RUN      = 2'b01
  } state_t;

  // Throttle plus signed trim, saturated to the 0..255 byte range.
  function automatic logic [7:0] clamp_val(input logic [7:0] ch, input logic [7:0] off);
    logic [9:0] sum;
    sum = {2'b00, ch} + {{2{off[7]}}, off};
    if (sum[9])
      return 8'd0;
    else if (sum[8])
      return 8'hFF;
    else
      return sum[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_chan.sv
`default_nettype none
// ----------------------------------------------------------------------
// pwm_chan - one PWM channel: width calc, shadow/active widths, comparator
// Rev 1.0 - initial release
// ----------------------------------------------------------------------
module pwm_chan
  import drone_pkg::*;
#(
  parameter int MIN_US  = 1000,
  parameter int MAX_US  = 2000,
  parameter int STEP_US = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        load,
  input  logic        force_min,
  input  logic [7:0]  ch,
  input  logic [7:0]  off,
  input  logic [14:0] us_cnt,
  output logic        pulse
);

  localparam width_t MIN_W = width_t'(MIN_US);
  localparam width_t MAX_W = width_t'(MAX_US);

  logic [7:0]  val;
  logic [15:0] raw;
  width_t      width;
  width_t      shadow;
  width_t      active;

  always_comb begin
    val   = clamp_val(ch, off);
    raw   = 16'(MIN_US) + 16'(STEP_US) * 16'(val);
    width = (raw > 16'(MAX_US)) ? MAX_W : raw[WIDTH_W-1:0];
  end

  // The comparator only ever sees active, so a capture mid-period never glitches the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= MIN_W;
      active <= MIN_W;
    end else begin
      if (capture)
        shadow <= width;
      if (load)
        active <= force_min ? MIN_W : shadow;
    end
  end

  assign pulse = ({4'd0, active} > us_cnt);

endmodule
`default_nettype wire

// File: rtl/pwm_channel_gen.sv
`default_nettype none
// ----------------------------------------------------------------------
// pwm_channel_gen - 4-channel ESC/servo PWM generator fed by the frame decoder
// Optional data-timeout failsafe enabled by defining FAILSAFE_EN.  Rev 1.0
// ----------------------------------------------------------------------
module pwm_channel_gen
  import drone_pkg::*;
#(
  parameter int CLKS_PER_US     = 50,
  parameter int PERIOD_US       = 20000,
  parameter int MIN_US          = 1000,
  parameter int MAX_US          = 2000,
  parameter int STEP_US         = 4
`ifdef FAILSAFE_EN
  ,
  parameter int TIMEOUT_PERIODS = 25
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sink_data_valid,
  input  logic [7:0] sink_CH1data,
  input  logic [7:0] sink_CH2data,
  input  logic [7:0] sink_CH3data,
  input  logic [7:0] sink_CH4data,
  input  logic [7:0] sink_offset1data,
  input  logic [7:0] sink_offset2data,
  input  logic [7:0] sink_offset3data,
  input  logic [7:0] sink_offset4data,
  output logic [3:0] pwm_out,
  output logic       armed,
  output logic       period_start,
  output logic       failsafe
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [PRE_W-1:0]  prescaler;
  logic [14:0]       us_cnt;
  logic              pre_wrap;
  logic              boundary;
  logic              prev_valid;
  logic              data_edge;
  logic              force_min;
  logic              arm_req;
  logic [NUM_CH-1:0] chan_pulse;
  logic [7:0]        ch_bus  [NUM_CH];
  logic [7:0]        off_bus [NUM_CH];
  state_t            state;
  state_t            state_next;

  assign ch_bus[0]  = sink_CH1data;
  assign ch_bus[1]  = sink_CH2data;
  assign ch_bus[2]  = sink_CH3data;
  assign ch_bus[3]  = sink_CH4data;
  assign off_bus[0] = sink_offset1data;
  assign off_bus[1] = sink_offset2data;
  assign off_bus[2] = sink_offset3data;
  assign off_bus[3] = sink_offset4data;

  assign pre_wrap = (prescaler == PRE_W'(CLKS_PER_US - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      us_cnt    <= '0;
    end else if (pre_wrap) begin
      prescaler <= '0;
      us_cnt    <= (us_cnt == 15'(PERIOD_US - 1)) ? 15'd0 : us_cnt + 15'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign boundary     = (prescaler == '0) && (us_cnt == '0);
  assign period_start = boundary && !reset;

  // The decoder toggles rather than pulses, so either transition means new data.
  always_ff @(posedge clk) begin
    if (reset)
      prev_valid <= 1'b0;
    else
      prev_valid <= sink_data_valid;
  end

  assign data_edge = sink_data_valid ^ prev_valid;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    pwm_chan #(
      .MIN_US  (MIN_US),
      .MAX_US  (MAX_US),
      .STEP_US (STEP_US)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .capture   (data_edge),
      .load      (boundary),
      .force_min (force_min),
      .ch        (ch_bus[n]),
      .off       (off_bus[n]),
      .us_cnt    (us_cnt),
      .pulse     (chan_pulse[n])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      arm_req <= 1'b0;
    else if (state == S_RUN)
      arm_req <= 1'b0;
    else if (data_edge)
      arm_req <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_DISARMED;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pwm_out    = '0;
    armed      = 1'b0;
    case (state)
      S_DISARMED: begin
        if (boundary && arm_req)
          state_next = S_RUN;
      end
      S_RUN: begin
        pwm_out = chan_pulse;
        armed   = 1'b1;
      end
      default: state_next = S_DISARMED;
    endcase
  end

`ifdef FAILSAFE_EN
  localparam int TO_W = $clog2(TIMEOUT_PERIODS + 1);

  logic [TO_W-1:0] period_cnt;
  logic            fs_active;
  logic            timeout_hit;

  assign timeout_hit = boundary && !data_edge && !fs_active &&
                       (period_cnt == TO_W'(TIMEOUT_PERIODS - 1));
  // The boundary that reaches the timeout already idles the motors.
  assign force_min   = !data_edge && (fs_active || timeout_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
      fs_active  <= 1'b0;
    end else if (data_edge) begin
      period_cnt <= '0;
      fs_active  <= 1'b0;
    end else if (boundary && !fs_active) begin
      period_cnt <= period_cnt + 1'b1;
      if (timeout_hit)
        fs_active <= 1'b1;
    end
  end

  assign failsafe = fs_active;
`else
  assign force_min = 1'b0;
  assign failsafe  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_channel_gen.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_pwm_channel_gen - directed bench; 1 clk per us so widths read directly in clocks
// Rev 1.0
// ----------------------------------------------------------------------
module tb_pwm_channel_gen;

  localparam int CPU  = 1;
  localparam int PER  = 3000;
  localparam int PCLK = CPU * PER;

  logic       clk;
  logic       reset;
  logic       sink_data_valid;
  logic [7:0] ch1, ch2, ch3, ch4;
  logic [7:0] of1, of2, of3, of4;
  logic [3:0] pwm_out;
  logic       armed;
  logic       period_start;
  logic       failsafe;

  int errors = 0;
  int checks = 0;

  pwm_channel_gen #(
    .CLKS_PER_US (CPU),
    .PERIOD_US   (PER)
`ifdef FAILSAFE_EN
    ,
    .TIMEOUT_PERIODS (3)
`endif
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .sink_data_valid  (sink_data_valid),
    .sink_CH1data     (ch1),
    .sink_CH2data     (ch2),
    .sink_CH3data     (ch3),
    .sink_CH4data     (ch4),
    .sink_offset1data (of1),
    .sink_offset2data (of2),
    .sink_offset3data (of3),
    .sink_offset4data (of4),
    .pwm_out          (pwm_out),
    .armed            (armed),
    .period_start     (period_start),
    .failsafe         (failsafe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for a period_start, then counts high clocks per channel over one period.
  // Optionally toggles sink_data_valid at clock act_at of that period. Ends on the next boundary.
  task automatic measure(input int act_at, output int hi [4], output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    for (int k = 0; k < 4; k++) hi[k] = 0;
    while (period_start !== 1'b1 && n < 2 * PCLK) begin
      @(negedge clk);
      n++;
    end
    if (period_start === 1'b1) begin
      ok = 1'b1;
      for (int c = 0; c < PCLK; c++) begin
        if (c == act_at) sink_data_valid = ~sink_data_valid;
        for (int k = 0; k < 4; k++)
          if (pwm_out[k] === 1'b1) hi[k]++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    int gap;
    int bad;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL rst_pwm: got %b want 0000", pwm_out); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b want 0", armed); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_period_start: got %b want 0", period_start); end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL rst_failsafe: got %b want 0", failsafe); end
    reset = 1'b0;
    @(negedge clk);
    bad = 0;
    gap = 0;
    while (period_start !== 1'b1 && gap < 2 * PCLK) begin
      @(negedge clk);
      gap++;
    end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin
        if (pwm_out !== 4'b0000 || armed !== 1'b0) bad++;
        @(negedge clk);
        gap++;
      end while (period_start !== 1'b1 && gap < 2 * PCLK);
      checks++; if (gap !== PCLK) begin errors++; $display("FAIL idle_period%0d: got %0d clks between period_start want %0d", p, gap, PCLK); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_outputs: got %0d cycles with pwm/armed active want 0", bad); end
  endtask

  task automatic test_arm;
    int  hi [4];
    int  ex [4];
    int  n;
    bit  ok;
    ex = '{1512, 2000, 1000, 1136};
    repeat (10) @(negedge clk);
    ch1 = 8'h80; of1 = 8'h00;
    ch2 = 8'hFF; of2 = 8'h10;
    ch3 = 8'h05; of3 = 8'hF0;
    ch4 = 8'h20; of4 = 8'h02;
    sink_data_valid = ~sink_data_valid;
    @(negedge clk);
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL arm_early: got %b want 0", armed); end
    n = 0;
    while (period_start !== 1'b1 && n < 2 * PCLK) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL arm_after_boundary: got %b want 1", armed); end
    measure(100, hi, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arm_measure: got no period_start want one"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (hi[k] !== ex[k] * CPU) begin errors++; $display("FAIL arm_width_ch%0d: got %0d us want %0d us", k + 1, hi[k] / CPU, ex[k]); end
    end
  endtask

  task automatic test_mid_pulse;
    int  hi [4];
    int  ex [4];
    bit  ok;
    ch1 = 8'h00;
    measure(500, hi, ok);
    ex = '{1512, 2000, 1000, 1136};
    checks++; if (!ok || hi[0] !== ex[0] * CPU) begin errors++; $display("FAIL mid_cur_ch1: got %0d us want %0d us", hi[0] / CPU, ex[0]); end
    checks++; if (hi[1] !== ex[1] * CPU) begin errors++; $display("FAIL mid_cur_ch2: got %0d us want %0d us", hi[1] / CPU, ex[1]); end
    measure(-1, hi, ok);
    ex = '{1000, 2000, 1000, 1136};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || hi[k] !== ex[k] * CPU) begin errors++; $display("FAIL mid_next_ch%0d: got %0d us want %0d us", k + 1, hi[k] / CPU, ex[k]); end
    end
  endtask

  task automatic test_back_to_back;
    int  hi [4];
    bit  ok;
    ch1 = 8'h40;
    measure(0, hi, ok);
    checks++; if (!ok || hi[0] !== 1000 * CPU) begin errors++; $display("FAIL b2b_same_period_ch1: got %0d us want 1000 us", hi[0] / CPU); end
    measure(-1, hi, ok);
    checks++; if (!ok || hi[0] !== 1256 * CPU) begin errors++; $display("FAIL b2b_next_period_ch1: got %0d us want 1256 us", hi[0] / CPU); end
    checks++; if (hi[3] !== 1136 * CPU) begin errors++; $display("FAIL b2b_next_period_ch4: got %0d us want 1136 us", hi[3] / CPU); end
  endtask

  task automatic test_reset_mid;
    repeat (700) @(negedge clk);
    checks++; if (pwm_out !== 4'b1111) begin errors++; $display("FAIL rmid_before: got %b want 1111", pwm_out); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL rmid_pwm: got %b want 0000", pwm_out); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL rmid_armed: got %b want 0", armed); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rmid_period_start: got %b want 0", period_start); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int  hi [4];
    int  prog [4];
    int  idle [4];
    int  ex3 [4];
    bit  ok;
    bit  fs_exp;
    prog = '{1256, 2000, 1000, 1136};
    idle = '{1000, 1000, 1000, 1000};
`ifdef FAILSAFE_EN
    ex3    = idle;
    fs_exp = 1'b1;
`else
    ex3    = prog;
    fs_exp = 1'b0;
`endif
    repeat (10) @(negedge clk);
    sink_data_valid = ~sink_data_valid;
    measure(-1, hi, ok);
    checks++; if (!ok || armed !== 1'b1) begin errors++; $display("FAIL to_rearm: got armed=%b want 1", armed); end
    measure(-1, hi, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || hi[k] !== prog[k] * CPU) begin errors++; $display("FAIL to_p2_ch%0d: got %0d us want %0d us", k + 1, hi[k] / CPU, prog[k]); end
    end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL to_p2_failsafe: got %b want 0", failsafe); end
    measure(-1, hi, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || hi[k] !== ex3[k] * CPU) begin errors++; $display("FAIL to_p3_ch%0d: got %0d us want %0d us", k + 1, hi[k] / CPU, ex3[k]); end
    end
    checks++; if (failsafe !== fs_exp) begin errors++; $display("FAIL to_p3_failsafe: got %b want %b", failsafe, fs_exp); end
    measure(100, hi, ok);
    checks++; if (!ok || hi[0] !== ex3[0] * CPU) begin errors++; $display("FAIL to_p4_ch1: got %0d us want %0d us", hi[0] / CPU, ex3[0]); end
    checks++; if (failsafe !== 1'b0) begin errors++; $display("FAIL to_p4_failsafe: got %b want 0", failsafe); end
    measure(-1, hi, ok);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!ok || hi[k] !== prog[k] * CPU) begin errors++; $display("FAIL to_p5_ch%0d: got %0d us want %0d us", k + 1, hi[k] / CPU, prog[k]); end
    end
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL to_p5_armed: got %b want 1", armed); end
  endtask

  initial begin
    reset = 1'b1;
    sink_data_valid = 1'b0;
    ch1 = 8'h00; ch2 = 8'h00; ch3 = 8'h00; ch4 = 8'h00;
    of1 = 8'h00; of2 = 8'h00; of3 = 8'h00; of4 = 8'h00;
    @(negedge clk);
    test_reset();
    test_arm();
    test_mid_pulse();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
